// File: rtl/output_handler.sv
// rtl/output_handler.sv - serialises command + result buffer as an ASCII hex frame to the UART
// Optional checksum bytes before the terminator: OUTPUT_HANDLER_CHECKSUM_EN.
module output_handler #(
  parameter logic [7:0] ID_CHAR     = 8'h4C,
  parameter logic [7:0] TERM_CHAR   = 8'h0A,
  parameter int         MAX_NIBBLES = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [7:0]   command,
  input  logic [15:0]  data_count,
  input  logic [255:0] buffer,
  input  logic         byte_ready,
  output logic [7:0]   byte_out,
  output logic         byte_valid,
  output logic         busy,
  output logic         done
);

`ifdef OUTPUT_HANDLER_CHECKSUM_EN
  typedef enum logic [2:0] {S_IDLE, S_ID, S_CMD, S_DATA, S_CSUM, S_TERM, S_DONE} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_ID, S_CMD, S_DATA, S_TERM, S_DONE} state_t;
`endif

  state_t         state;
  logic [3:0]     cmd_q;
  logic [255:0]   buf_q;
  logic [6:0]     n_q;
  logic [6:0]     idx;
  logic [6:0]     n_in;
  logic [6:0]     sel_idx;
  logic [3:0]     sel_nib;
  logic           xfer;
  logic           unused_cmd_hi;

  function automatic logic [7:0] hex2ascii(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
  endfunction

  assign xfer          = byte_valid & byte_ready;
  assign unused_cmd_hi = ^command[7:4];
  assign n_in          = (data_count > 16'(MAX_NIBBLES)) ? 7'(MAX_NIBBLES) : data_count[6:0];
  // Nibble presented after the current transfer: first data nibble from CMD, else the next lower one.
  assign sel_idx       = (state == S_CMD) ? (n_q - 7'd1) : (idx - 7'd1);
  assign sel_nib       = buf_q[{sel_idx[5:0], 2'b00} +: 4];

`ifdef OUTPUT_HANDLER_CHECKSUM_EN
  logic [7:0] sum;
  logic [7:0] sum_next;
  logic [3:0] add_nib;
  logic       csum_lo;

  // Sum including the byte being transferred, so CSUM can present its high digit on the same edge.
  assign add_nib  = (state == S_CMD) ? cmd_q : buf_q[{idx[5:0], 2'b00} +: 4];
  assign sum_next = sum + {4'h0, add_nib};
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_IDLE;
      cmd_q      <= '0;
      buf_q      <= '0;
      n_q        <= '0;
      idx        <= '0;
      byte_out   <= '0;
      byte_valid <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
`ifdef OUTPUT_HANDLER_CHECKSUM_EN
      sum        <= '0;
      csum_lo    <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            cmd_q      <= command[3:0];
            buf_q      <= buffer;
            n_q        <= n_in;
            idx        <= '0;
            busy       <= 1'b1;
            byte_out   <= ID_CHAR;
            byte_valid <= 1'b1;
            state      <= S_ID;
`ifdef OUTPUT_HANDLER_CHECKSUM_EN
            sum        <= '0;
            csum_lo    <= 1'b0;
`endif
          end
        end
        S_ID: begin
          if (xfer) begin
            byte_out <= hex2ascii(cmd_q);
            state    <= S_CMD;
          end
        end
        S_CMD: begin
          if (xfer) begin
`ifdef OUTPUT_HANDLER_CHECKSUM_EN
            sum <= sum_next;
`endif
            if (n_q != 7'd0) begin
              idx      <= n_q - 7'd1;
              byte_out <= hex2ascii(sel_nib);
              state    <= S_DATA;
            end else begin
`ifdef OUTPUT_HANDLER_CHECKSUM_EN
              byte_out <= hex2ascii(sum_next[7:4]);
              state    <= S_CSUM;
`else
              byte_out <= TERM_CHAR;
              state    <= S_TERM;
`endif
            end
          end
        end
        S_DATA: begin
          if (xfer) begin
`ifdef OUTPUT_HANDLER_CHECKSUM_EN
            sum <= sum_next;
`endif
            if (idx != 7'd0) begin
              idx      <= idx - 7'd1;
              byte_out <= hex2ascii(sel_nib);
            end else begin
`ifdef OUTPUT_HANDLER_CHECKSUM_EN
              byte_out <= hex2ascii(sum_next[7:4]);
              state    <= S_CSUM;
`else
              byte_out <= TERM_CHAR;
              state    <= S_TERM;
`endif
            end
          end
        end
`ifdef OUTPUT_HANDLER_CHECKSUM_EN
        S_CSUM: begin
          if (xfer) begin
            if (!csum_lo) begin
              byte_out <= hex2ascii(sum[3:0]);
              csum_lo  <= 1'b1;
            end else begin
              byte_out <= TERM_CHAR;
              state    <= S_TERM;
            end
          end
        end
`endif
        S_TERM: begin
          if (xfer) begin
            byte_valid <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b1;
            state      <= S_DONE;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_output_handler.sv
// tb/tb_output_handler.sv - directed self-checking bench for output_handler
module tb_output_handler;
  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start = 1'b0;
  logic [7:0]   command = '0;
  logic [15:0]  data_count = '0;
  logic [255:0] buffer = '0;
  logic         byte_ready = 1'b0;
  logic [7:0]   byte_out;
  logic         byte_valid;
  logic         busy;
  logic         done;

  always #5 clk = ~clk;

  output_handler dut (
    .clk(clk), .rst(rst), .start(start), .command(command),
    .data_count(data_count), .buffer(buffer), .byte_ready(byte_ready),
    .byte_out(byte_out), .byte_valid(byte_valid), .busy(busy), .done(done)
  );

  int n_checks = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];
  int         done_cnt = 0;
  int         stall_err = 0;
  int         both_err = 0;
  int         run = 0;
  int         last_run = 0;
  bit         stall_pend = 1'b0;
  logic [7:0] stall_byte = '0;

  logic [7:0] digits [16] = '{8'h30, 8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37,
                              8'h38, 8'h39, 8'h41, 8'h42, 8'h43, 8'h44, 8'h45, 8'h46};
  logic [255:0] buf2 = {{48{4'h9}}, 64'h0123456789ABCDEF};

  // Transfer happens on the posedge after a negedge that sees valid && ready.
  always @(negedge clk) begin
    if (byte_valid && byte_ready) got_q.push_back(byte_out);
    if (stall_pend && byte_valid && byte_out != stall_byte) stall_err++;
    stall_pend = byte_valid && !byte_ready;
    stall_byte = byte_out;
    if (done) done_cnt++;
    if (done && busy) both_err++;
    if (byte_valid) run++;
    else begin
      if (run > 0) last_run = run;
      run = 0;
    end
  end

  task automatic exp_basic();
    exp_q.delete();
    exp_q.push_back(8'h4C);
    exp_q.push_back(8'h31);
    for (int i = 0; i < 16; i++) exp_q.push_back(digits[i]);
`ifdef OUTPUT_HANDLER_CHECKSUM_EN
    exp_q.push_back(8'h37);
    exp_q.push_back(8'h39);
`endif
    exp_q.push_back(8'h0A);
  endtask

  task automatic start_frame(input logic [7:0] c, input logic [15:0] cnt, input logic [255:0] b);
    @(posedge clk); #1;
    got_q.delete();
    command = c; data_count = cnt; buffer = b;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int mode);
    bit ok = 1'b0;
    for (int i = 0; i < 800; i++) begin
      if (done) begin ok = 1'b1; break; end
      byte_ready = (mode == 0) ? 1'b1 : ((i % 4 == 0) || (i % 4 == 3));
      @(posedge clk); #1;
    end
    byte_ready = 1'b1;
    check({tag, " done seen"}, 32'(ok), 32'd1);
    check({tag, " busy at done"}, 32'(busy), 32'd0);
    @(negedge clk); #1;
  endtask

  task automatic wait_size(input string tag, input int n);
    bit ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (got_q.size() >= n) begin ok = 1'b1; break; end
      @(posedge clk); #1;
    end
    check({tag, " reached byte count"}, 32'(ok), 32'd1);
  endtask

  task automatic compare_stream(input string tag);
    int n;
    check({tag, " len"}, 32'(got_q.size()), 32'(exp_q.size()));
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++)
      check($sformatf("%s byte%0d", tag, i), 32'(got_q[i]), 32'(exp_q[i]));
  endtask

  initial begin
    int base;
    int sz;
    // 1: reset values
    #2;
    check("rst byte_out", 32'(byte_out), 32'd0);
    check("rst byte_valid", 32'(byte_valid), 32'd0);
    check("rst busy", 32'(busy), 32'd0);
    check("rst done", 32'(done), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    byte_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("idle byte_valid", 32'(byte_valid), 32'd0);
    check("idle busy", 32'(busy), 32'd0);

    // 2: basic frame, ready held high
    exp_basic();
    base = done_cnt;
    start_frame(8'h01, 16'd16, buf2);
    check("t2 first byte", 32'(byte_out), 32'h4C);
    check("t2 first valid", 32'(byte_valid), 32'd1);
    check("t2 busy", 32'(busy), 32'd1);
    wait_done("t2", 0);
    compare_stream("t2");
    check("t2 done pulses", 32'(done_cnt - base), 32'd1);
    check("t2 valid run", 32'(last_run), 32'(exp_q.size()));
    check("t2 valid after", 32'(byte_valid), 32'd0);

    // 3: backpressure 1,0,0,1
    stall_err = 0;
    start_frame(8'h01, 16'd16, buf2);
    wait_done("t3", 1);
    compare_stream("t3");
    check("t3 stall stable", 32'(stall_err), 32'd0);

    // 4a: zero data
    exp_q.delete();
    exp_q.push_back(8'h4C); exp_q.push_back(8'h41);
`ifdef OUTPUT_HANDLER_CHECKSUM_EN
    exp_q.push_back(8'h30); exp_q.push_back(8'h41);
`endif
    exp_q.push_back(8'h0A);
    start_frame(8'h0A, 16'd0, buf2);
    wait_done("t4z", 0);
    compare_stream("t4z");

    // 4b: clamp 256 -> 64 nibbles
    exp_q.delete();
    exp_q.push_back(8'h4C); exp_q.push_back(8'h35);
    for (int i = 0; i < 64; i++) exp_q.push_back(8'h46);
`ifdef OUTPUT_HANDLER_CHECKSUM_EN
    exp_q.push_back(8'h43); exp_q.push_back(8'h35);
`endif
    exp_q.push_back(8'h0A);
    start_frame(8'h05, 16'h0100, {256{1'b1}});
    wait_done("t4c", 0);
    compare_stream("t4c");

    // 5a: start and input changes mid-frame are ignored
    exp_basic();
    base = done_cnt;
    start_frame(8'h01, 16'd16, buf2);
    wait_size("t5i", 6);
    command = 8'h0F; data_count = 16'd3; buffer = '0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done("t5i", 0);
    sz = got_q.size();
    repeat (10) @(posedge clk);
    #1;
    compare_stream("t5i");
    check("t5i no second frame", 32'(got_q.size()), 32'(sz));
    check("t5i done pulses", 32'(done_cnt - base), 32'd1);

    // 5b: abort after 5 data bytes, then a fresh frame
    start_frame(8'h01, 16'd16, buf2);
    wait_size("t5a", 7);
    @(posedge clk); #1;
    base = done_cnt;
    rst = 1'b0;
    #1;
    check("t5a valid dropped", 32'(byte_valid), 32'd0);
    check("t5a busy dropped", 32'(busy), 32'd0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("t5a no done", 32'(done_cnt - base), 32'd0);
    start_frame(8'h01, 16'd16, buf2);
    wait_done("t5f", 0);
    compare_stream("t5f");

    check("done with busy", 32'(both_err), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
